// File: rtl/wfg_spi_sink.sv
// SPI receive sink for the WFG SPI driver: oversampled SPI slave that assembles
// 8/16/24/32-bit words and queues them in a first-word-fall-through FIFO.
module wfg_spi_sink #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        en_i,
   input  logic        cpol_i,
   input  logic        cpha_i,
   input  logic        lsbfirst_i,
   input  logic [1:0]  dff_i,
   input  logic        sclk_i,
   input  logic        cs_i,
   input  logic        sdo_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o,
   output logic        frame_err_o,
   input  logic        clear_i
);

   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic {IDLE, RECV} state_t;

   state_t      state;
   logic        sclk_s1, sclk_s2, sclk_d;
   logic        cs_s1, cs_s2, cs_d;
   logic        sdo_s1, sdo_s2;
   logic        sync_live, armed;
   logic        fall_mode, lsb_mode;
   logic [5:0]  word_len;
   logic [5:0]  bit_cnt;
   logic [31:0] shreg;

   logic [31:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;

   logic        sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic        sample, word_done, full, pop, push;
   logic [31:0] word_next;

   assign sclk_rise = sclk_s2 & ~sclk_d;
   assign sclk_fall = ~sclk_s2 & sclk_d;
   // A cs low level already present when reset released must not look like a frame start.
   assign cs_fall   = ~cs_s2 & cs_d & armed;
   assign cs_rise   = cs_s2 & ~cs_d;

   assign sample    = (state == RECV) & en_i & ~cs_rise & (fall_mode ? sclk_fall : sclk_rise);
   assign word_next = lsb_mode ? (shreg | (32'(sdo_s2) << bit_cnt)) : {shreg[30:0], sdo_s2};
   assign word_done = sample & ((bit_cnt + 6'd1) == word_len);

   assign full    = (count == (AW+1)'(FIFO_DEPTH));
   assign valid_o = (count != '0);
   assign pop     = valid_o & ready_i;
   assign push    = word_done & (~full | pop);
   assign data_o  = valid_o ? mem[rd_ptr] : '0;

   // NOTE: storage array has no reset; data_o is masked by valid_o instead.
   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr] <= word_next;
   end

   // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state       <= IDLE;
         sclk_s1     <= 1'b0;
         sclk_s2     <= 1'b0;
         sclk_d      <= 1'b0;
         cs_s1       <= 1'b1;
         cs_s2       <= 1'b1;
         cs_d        <= 1'b1;
         sdo_s1      <= 1'b0;
         sdo_s2      <= 1'b0;
         sync_live   <= 1'b0;
         armed       <= 1'b0;
         fall_mode   <= 1'b0;
         lsb_mode    <= 1'b0;
         word_len    <= 6'd8;
         bit_cnt     <= '0;
         shreg       <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow_o  <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         sclk_s1   <= sclk_i;
         sclk_s2   <= sclk_s1;
         sclk_d    <= sclk_s2;
         cs_s1     <= cs_i;
         cs_s2     <= cs_s1;
         cs_d      <= cs_s2;
         sdo_s1    <= sdo_i;
         sdo_s2    <= sdo_s1;
         sync_live <= 1'b1;
         if (sync_live && cs_s1) armed <= 1'b1;

         frame_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (en_i && cs_fall) begin
                  state     <= RECV;
                  fall_mode <= cpol_i ^ cpha_i;
                  lsb_mode  <= lsbfirst_i;
                  word_len  <= {({1'b0, dff_i} + 3'd1), 3'b000};
                  bit_cnt   <= '0;
                  shreg     <= '0;
               end
            end
            RECV: begin
               if (!en_i) begin
                  state <= IDLE;
               end else if (cs_rise) begin
                  state       <= IDLE;
                  frame_err_o <= (bit_cnt != '0);
               end else if (sample) begin
                  if (word_done) begin
                     bit_cnt <= '0;
                     shreg   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                     shreg   <= word_next;
                  end
               end
            end
            default: state <= IDLE;
         endcase

         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         overflow_o <= (overflow_o & ~clear_i) | (word_done & full & ~pop);
      end
   end

endmodule

// File: tb/tb_wfg_spi_sink.sv
// Directed bench for wfg_spi_sink: SPI frames driven at clk/8 with hand-computed
// expected words, FIFO/overflow/frame-error behaviour and reset recovery.
module tb_wfg_spi_sink;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, cpol, cpha, lsb;
   logic [1:0]  dff;
   logic        sclk, cs, sdo;
   logic [31:0] data;
   logic        valid, ready, overflow, frame_err, clear;

   int checks   = 0;
   int failures = 0;
   int ferr_cnt = 0;

   always #5 clk = ~clk;

   wfg_spi_sink #(.FIFO_DEPTH(4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .en_i       (en),
      .cpol_i     (cpol),
      .cpha_i     (cpha),
      .lsbfirst_i (lsb),
      .dff_i      (dff),
      .sclk_i     (sclk),
      .cs_i       (cs),
      .sdo_i      (sdo),
      .data_o     (data),
      .valid_o    (valid),
      .ready_i    (ready),
      .overflow_o (overflow),
      .frame_err_o(frame_err),
      .clear_i    (clear)
   );

   // Counts clock cycles during which frame_err_o is high.
   always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic half();
      repeat (4) @(negedge clk);
   endtask

   // act 0: plain half period; 1: check valid latency; 2: pulse ready in the push cycle.
   task automatic tail(input int act);
      if (act == 0) begin
         half();
      end else if (act == 1) begin
         @(posedge clk); @(posedge clk); #1;
         check("latency_edge2_valid", 32'(valid), 32'd0);
         @(posedge clk); #1;
         check("latency_edge3_valid", 32'(valid), 32'd1);
         @(negedge clk); @(negedge clk);
      end else begin
         @(posedge clk); @(posedge clk); @(negedge clk);
         ready = 1'b1;
         @(negedge clk);
         ready = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic send_bits(input logic [31:0] w, input int n, input int act);
      logic b;
      for (int i = 0; i < n; i++) begin
         b = lsb ? w[i] : w[n-1-i];
         if (!cpha) begin
            sdo = b;
            half();
            sclk = ~cpol;
            tail((i == n-1) ? act : 0);
            sclk = cpol;
         end else begin
            sclk = ~cpol;
            sdo  = b;
            half();
            sclk = cpol;
            tail((i == n-1) ? act : 0);
         end
      end
   endtask

   task automatic set_mode(input logic p, input logic h, input logic l, input logic [1:0] d);
      cpol = p; cpha = h; lsb = l; dff = d;
      sclk = p;
      half();
   endtask

   task automatic start_frame();
      cs = 1'b0;
      half();
   endtask

   task automatic end_frame();
      half();
      cs = 1'b1;
      half();
      half();
   endtask

   task automatic send_word(input logic [31:0] w, input int n);
      start_frame();
      send_bits(w, n, 0);
      end_frame();
   endtask

   task automatic pop_check(input string tag, input logic [31:0] exp);
      check({tag, "_valid"}, 32'(valid), 32'd1);
      check({tag, "_data"}, data, exp);
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; dff = 2'd0;
      sclk = 1'b0; cs = 1'b1; sdo = 1'b0; ready = 1'b0; clear = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);

      // Mode 0, MSB-first, 8 bits, with push latency measured on the last sample.
      set_mode(1'b0, 1'b0, 1'b0, 2'd0);
      start_frame();
      send_bits(32'hA5, 8, 1);
      end_frame();
      pop_check("mode0_a5", 32'h0000_00A5);
      check("mode0_empty", 32'(valid), 32'd0);

      // Mode 3, LSB-first, 32-bit, two words under one chip select.
      set_mode(1'b1, 1'b1, 1'b1, 2'd3);
      start_frame();
      send_bits(32'hDEAD_BEEF, 32, 0);
      send_bits(32'h1234_5678, 32, 0);
      end_frame();
      pop_check("mode3_w0", 32'hDEAD_BEEF);
      pop_check("mode3_w1", 32'h1234_5678);
      check("mode3_empty", 32'(valid), 32'd0);
      check("mode3_no_ferr", 32'(ferr_cnt), 32'd0);

      // Five words with ready low: first four kept, overflow sticky until cleared.
      set_mode(1'b0, 1'b0, 1'b0, 2'd0);
      send_word(32'h11, 8);
      send_word(32'h22, 8);
      send_word(32'h33, 8);
      check("ovf_before_full", 32'(overflow), 32'd0);
      send_word(32'h44, 8);
      check("ovf_at_full", 32'(overflow), 32'd0);
      send_word(32'h55, 8);
      check("ovf_set", 32'(overflow), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("ovf_cleared", 32'(overflow), 32'd0);
      pop_check("drain0", 32'h11);
      pop_check("drain1", 32'h22);
      pop_check("drain2", 32'h33);
      pop_check("drain3", 32'h44);
      check("drain_empty", 32'(valid), 32'd0);

      // 16-bit mode, chip select raised after 9 bits, then a full 0xBEEF frame.
      set_mode(1'b0, 1'b0, 1'b0, 2'd1);
      send_word(32'h1FF, 9);
      check("ferr_pulse_one_cycle", 32'(ferr_cnt), 32'd1);
      check("ferr_nothing_pushed", 32'(valid), 32'd0);
      send_word(32'hBEEF, 16);
      pop_check("after_ferr_beef", 32'h0000_BEEF);
      check("after_ferr_no_new_err", 32'(ferr_cnt), 32'd1);

      // Enable dropped mid-frame: partial word discarded, no frame error.
      set_mode(1'b0, 1'b0, 1'b0, 2'd0);
      start_frame();
      send_bits(32'hF, 4, 0);
      en = 1'b0;
      half();
      send_bits(32'hF, 4, 0);
      end_frame();
      en = 1'b1;
      half();
      check("en_drop_no_word", 32'(valid), 32'd0);
      check("en_drop_no_ferr", 32'(ferr_cnt), 32'd1);

      // FIFO full; ready pulsed in the cycle the fifth word is pushed.
      send_word(32'h01, 8);
      send_word(32'h02, 8);
      send_word(32'h03, 8);
      send_word(32'h04, 8);
      start_frame();
      send_bits(32'h05, 8, 2);
      end_frame();
      check("push_pop_full_no_ovf", 32'(overflow), 32'd0);
      pop_check("pp0", 32'h02);
      pop_check("pp1", 32'h03);
      pop_check("pp2", 32'h04);
      pop_check("pp3", 32'h05);
      check("pp_empty", 32'(valid), 32'd0);

      // Fill and overflow, then reset in the middle of a 0x3C frame.
      for (int k = 0; k < 5; k++) send_word(32'hA0 + 32'(k), 8);
      check("pre_rst_overflow", 32'(overflow), 32'd1);
      check("pre_rst_valid", 32'(valid), 32'd1);
      start_frame();
      send_bits(32'h07, 5, 0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_data", data, 32'd0);
      check("midrst_overflow", 32'(overflow), 32'd0);
      check("midrst_frame_err", 32'(frame_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send_bits(32'h4, 3, 0);
      end_frame();
      check("rst_frame_ignored", 32'(valid), 32'd0);
      check("rst_frame_no_ferr", 32'(ferr_cnt), 32'd1);
      send_word(32'h3C, 8);
      pop_check("restart_3c", 32'h0000_003C);
      check("final_empty", 32'(valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
